row_band_feeder: RTL
====================

Name: row_band_feeder

Overview:
- Input stage directly upstream of the dual-kernel convolution datapath.
- Accepts a raster pixel stream and buffers 4 image rows in a circular row store.
- Presents one 4-pixel vertical column per handshake on in1..in4, which feed the two 3x3 kernels (rows 0-2 and rows 1-3).
- Steps down the image 2 rows per band, matching the two output rows produced per band.

Parameters:
- IMG_W, 8, pixels per row (>=3).
- IMG_H, 8, rows per frame (even, >=4).
- DW, 8, pixel width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- pix_in  in  DW  raster pixel data.
- pix_valid  in  1  pix_in valid.
- pix_ready  out  1  feeder accepts a pixel this cycle.
- in1, in2, in3, in4  out  DW each  column pixels, top (oldest row) to bottom.
- col_valid  out  1  column on in1..in4 valid; doubles as the kernel shift strobe.
- col_ready  in  1  downstream accepts the column.
- band_last  out  1  high with col_valid on the final column of a band.
- frame_done  out  1  one-cycle pulse when the frame completes.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RESET=1): state IDLE; all counters and top_ptr = 0.
  - Outputs: pix_ready=0, col_valid=0, band_last=0, frame_done=0, busy=0, in1..in4=0.
  - Row store contents are not reset.
- in1..in4 are forced to 0 whenever col_valid=0.
- States:
  - IDLE: start=1 -> FILL, with wr_row=0, wr_col=0, band=0, top_ptr=0.
  - FILL: pix_ready=1. Each pix_valid&pix_ready writes store[(top_ptr+wr_row)%4][wr_col], then wr_col++. At wr_col=IMG_W-1, wr_col wraps to 0 and wr_row++. After the write of row 3, col IMG_W-1 -> STREAM next cycle.
  - STREAM: pix_ready=0; col_valid=1 from the first STREAM cycle.
    - in_k = store[(top_ptr+k-1)%4][col_cnt].
    - col_valid&col_ready -> col_cnt++.
    - Data holds stable while col_ready=0.
    - band_last = (col_cnt==IMG_W-1).
    - On the accepted last column, col_cnt=0 and:
      - if band==(IMG_H-4)/2 -> DONE;
      - else -> REFILL, with band++ and wr_row=0.
  - REFILL: pix_ready=1. Writes overwrite the two oldest rows, store[(top_ptr+wr_row)%4], for wr_row 0..1. After the accepted write of wr_row=1, col IMG_W-1: top_ptr <= (top_ptr+2)%4 -> STREAM.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
- start is ignored while busy=1.
- pix_valid is ignored when pix_ready=0; no pixel is consumed in STREAM.
- Latency: the first col_valid appears 1 cycle after the last fill pixel is accepted.
- Bands per frame: (IMG_H-2)/2. Columns per band: IMG_W.
- RESET asserted mid-frame aborts immediately; no frame_done is produced. A fresh start is required.
- Counter widths: col/wr_col ceil(log2(IMG_W)), band ceil(log2(IMG_H)). All wrap explicitly as above; no unintended overflow.

Optional Feature:
- Macro: ROW_BAND_FEEDER_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0], reset 0, cleared on an accepted start.
  - Increments each cycle col_valid=1 && col_ready=0.
  - Saturates at 16'hFFFF.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- IMG_W=4, IMG_H=6; pixel = row*16+col; col_ready=1. Band0 col0 -> in1..4=0x00,0x10,0x20,0x30; col3 -> 0x03,0x13,0x23,0x33 with band_last=1. Band1 col0 -> 0x20,0x30,0x40,0x50. frame_done pulses once after 8 columns total.
- pix_valid toggles 1/0 each cycle during FILL -> exactly 16 pixels accepted; first col_valid 1 cycle after the 16th accept.
- col_ready=0 for 3 cycles on band0 col1 -> in1..4 hold 0x01,0x11,0x21,0x31; col_cnt does not advance. With the macro, stall_cnt=3.
- start pulsed during STREAM -> ignored; frame completes normally with exactly 2 bands.
- RESET pulsed during REFILL -> next cycle all outputs 0, busy=0. A new start refills 4 rows from top_ptr=0 with correct band0 data.
- IMG_H=4 -> single band, DONE directly after 4 columns, no REFILL entered.

Source files
------------

// File: rtl/row_band_feeder.sv
// Row band feeder: buffers 4 raster rows in a circular store and emits 4-pixel columns,
// advancing 2 rows per band. Define ROW_BAND_FEEDER_STALL_CNT_EN to add the stall_cnt output.
module row_band_feeder #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [DW-1:0] in1,
  output logic [DW-1:0] in2,
  output logic [DW-1:0] in3,
  output logic [DW-1:0] in4,
  output logic          col_valid,
  input  logic          col_ready,
  output logic          band_last,
  output logic          frame_done,
`ifdef ROW_BAND_FEEDER_STALL_CNT_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic          busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int BW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL  = CW'(IMG_W - 1);
  localparam logic [BW-1:0] LAST_BAND = BW'((IMG_H - 4) / 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state_reg;
  logic [CW-1:0] wr_col_reg;
  logic [1:0]    wr_row_reg;
  logic [CW-1:0] col_cnt_reg;
  logic [BW-1:0] band_reg;
  logic [1:0]    top_ptr_reg;

  logic [DW-1:0] store [4][IMG_W];
  logic [DW-1:0] col_pix [4];
  logic          pix_fire;
  logic          col_fire;
  logic [1:0]    wr_row_last;

  assign pix_ready   = (state_reg == S_FILL) || (state_reg == S_REFILL);
  assign col_valid   = (state_reg == S_STREAM);
  assign band_last   = col_valid && (col_cnt_reg == LAST_COL);
  assign frame_done  = (state_reg == S_DONE);
  assign busy        = (state_reg != S_IDLE);
  assign pix_fire    = pix_valid && pix_ready;
  assign col_fire    = col_valid && col_ready;
  // A full fill loads all 4 rows; a refill replaces only the 2 oldest.
  assign wr_row_last = (state_reg == S_FILL) ? 2'd3 : 2'd1;

  // Row store is not reset; the 2-bit pointer arithmetic wraps modulo 4 naturally.
  always_ff @(posedge CLK) begin
    if (pix_fire)
      store[top_ptr_reg + wr_row_reg][wr_col_reg] <= pix_in;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col_pix[gi] = col_valid ? store[top_ptr_reg + 2'(gi)][col_cnt_reg] : '0;
    end
  endgenerate

  assign in1 = col_pix[0];
  assign in2 = col_pix[1];
  assign in3 = col_pix[2];
  assign in4 = col_pix[3];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= S_IDLE;
      wr_col_reg  <= '0;
      wr_row_reg  <= '0;
      col_cnt_reg <= '0;
      band_reg    <= '0;
      top_ptr_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg   <= S_FILL;
            wr_col_reg  <= '0;
            wr_row_reg  <= '0;
            col_cnt_reg <= '0;
            band_reg    <= '0;
            top_ptr_reg <= '0;
          end
        end
        S_FILL, S_REFILL: begin
          if (pix_fire) begin
            if (wr_col_reg == LAST_COL) begin
              wr_col_reg <= '0;
              if (wr_row_reg == wr_row_last) begin
                wr_row_reg <= '0;
                state_reg  <= S_STREAM;
                if (state_reg == S_REFILL)
                  top_ptr_reg <= top_ptr_reg + 2'd2;
              end else begin
                wr_row_reg <= wr_row_reg + 2'd1;
              end
            end else begin
              wr_col_reg <= wr_col_reg + 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (col_fire) begin
            if (col_cnt_reg == LAST_COL) begin
              col_cnt_reg <= '0;
              if (band_reg == LAST_BAND) begin
                state_reg <= S_DONE;
              end else begin
                state_reg  <= S_REFILL;
                band_reg   <= band_reg + 1'b1;
                wr_row_reg <= '0;
                wr_col_reg <= '0;
              end
            end else begin
              col_cnt_reg <= col_cnt_reg + 1'b1;
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef ROW_BAND_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cnt_reg <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      stall_cnt_reg <= '0;
    end else if (col_valid && !col_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
